// File: rtl/plot_pkg.sv
// plot_pkg: shared resolution constants, framebuffer write record and the
// FSM state type for the pixel-plot framebuffer writer.
package plot_pkg;

  localparam int H_RES     = 160;
  localparam int V_RES     = 120;
  localparam int FB_ADDR_W = 15;
  localparam int FB_WORDS  = H_RES * V_RES;

  // Address of the last pixel; the clear sweep ends after writing it.
  localparam logic [FB_ADDR_W-1:0] FB_LAST = FB_ADDR_W'(FB_WORDS - 1);

  typedef struct packed {
    logic [14:0] addr;
    logic [2:0]  colour;
  } fb_wr_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLR_DRAIN = 2'd1,
    ST_CLR_SWEEP = 2'd2,
    ST_CLR_DONE  = 2'd3
  } plot_state_e;

endpackage

// File: rtl/plot_fifo.sv
// plot_fifo: synchronous FIFO of framebuffer writes. Head entry is visible on
// rd_data whenever the FIFO is not empty. Writes when full and reads when
// empty are ignored.
module plot_fifo
  import plot_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   wr_en,
  input  fb_wr_t wr_data,
  input  logic   rd_en,
  output fb_wr_t rd_data,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  fb_wr_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_wr;
  logic              do_rd;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array.
  // NOTE: the array has no reset; the occupancy count alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/plot_fb_writer.sv
// plot_fb_writer: accepts pixel plots over ready/valid, drops off-screen
// coordinates, queues on-screen writes and drives a stallable framebuffer
// write port. Also performs a full-screen clear sweep on request.
// Optional build macro PLOT_STATS_EN adds saturating accepted/clipped counters.
module plot_fb_writer
  import plot_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  plot_x,
  input  logic [6:0]  plot_y,
  input  logic [2:0]  plot_colour,
  input  logic        plot_valid,
  output logic        plot_ready,
  input  logic        clear_start,
  input  logic [2:0]  clear_colour,
  output logic        clear_done,
  output logic        busy,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_wdata,
  output logic        fb_we,
  input  logic        fb_wait
`ifdef PLOT_STATS_EN
  ,
  output logic [15:0] accepted_cnt,
  output logic [15:0] clipped_cnt
`endif
);

  localparam logic [7:0] H_LIM = 8'(H_RES);
  localparam logic [6:0] V_LIM = 7'(V_RES);

  plot_state_e state;
  logic [2:0]  clr_colour;
  logic [14:0] y_ext;
  fb_wr_t      fifo_din;
  fb_wr_t      fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        handshake;
  logic        in_range;
  logic        push;
  logic        pop;
  logic        wr_done;
  logic        sweep_go;
  logic        sweep_last;

  assign plot_ready = !rst && (state == ST_IDLE) && !fifo_full;
  assign handshake  = plot_valid && plot_ready;
  assign in_range   = (plot_x < H_LIM) && (plot_y < V_LIM);
  assign push       = handshake && in_range;

  // y*160 + x as two shifted copies of y plus x; fits in 15 bits for on-screen pixels.
  assign y_ext    = {8'd0, plot_y};
  assign fifo_din = {(y_ext << 7) + (y_ext << 5) + {7'd0, plot_x}, plot_colour};

  assign wr_done    = fb_we && !fb_wait;
  // Refill the output register when it is empty or its write completes this cycle.
  assign pop        = !fifo_empty && (!fb_we || wr_done);
  assign sweep_go   = (state == ST_CLR_DRAIN) && fifo_empty && !fb_we;
  assign sweep_last = (state == ST_CLR_SWEEP) && wr_done && (fb_addr == FB_LAST);

  assign clear_done = (state == ST_CLR_DONE);
  assign busy       = !fifo_empty || fb_we || (state != ST_IDLE);

  plot_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (fifo_din),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Clear sequencing: latch colour, drain queued plots, sweep, pulse done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      clr_colour <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear_start) begin
            clr_colour <= clear_colour;
            state      <= ST_CLR_DRAIN;
          end
        end
        ST_CLR_DRAIN: if (sweep_go)   state <= ST_CLR_SWEEP;
        ST_CLR_SWEEP: if (sweep_last) state <= ST_CLR_DONE;
        default:                      state <= ST_IDLE;
      endcase
    end
  end

  // Output register: holds one pending write, either a queued plot or the sweep pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_wdata <= '0;
    end else if (sweep_go) begin
      fb_we    <= 1'b1;
      fb_addr  <= '0;
      fb_wdata <= clr_colour;
    end else if (state == ST_CLR_SWEEP) begin
      if (wr_done) begin
        if (fb_addr == FB_LAST) fb_we   <= 1'b0;
        else                    fb_addr <= fb_addr + 15'd1;
      end
    end else if (pop) begin
      fb_we    <= 1'b1;
      fb_addr  <= fifo_head.addr;
      fb_wdata <= fifo_head.colour;
    end else if (wr_done) begin
      fb_we <= 1'b0;
    end
  end

`ifdef PLOT_STATS_EN
  // Saturating handshake statistics, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accepted_cnt <= '0;
      clipped_cnt  <= '0;
    end else begin
      if (handshake && accepted_cnt != 16'hFFFF)
        accepted_cnt <= accepted_cnt + 16'd1;
      if (handshake && !in_range && clipped_cnt != 16'hFFFF)
        clipped_cnt <= clipped_cnt + 16'd1;
    end
  end
`endif

endmodule
